// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode names and frame timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_tx_st_e;

  localparam string ParOdd  = "ODD";
  localparam string ParEven = "EVEN";
  localparam string ParNone = "NONE";

  // Clocks occupied by one complete frame on the line.
  function automatic int unsigned frame_clks(input int unsigned data_w,
                                             input bit          has_par,
                                             input int unsigned stop_bits,
                                             input int unsigned cpb);
    return (1 + data_w + (has_par ? 1 : 0) + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each serial bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o = !clr_i && (cnt_q == CntMax);

  // Next count: held at zero while cleared, wraps at the end of each bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start / DATA_W data bits LSB first / optional parity / stop bits.
// Define UART_TX_BREAK_EN to add the tx_break_i port and the line-break state.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter string       PARITY       = "ODD",
  parameter int unsigned STOP_BIT     = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_rdy_i,
  input  logic [DATA_W-1:0] tx_data_i,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break_i,
`endif
  output logic              tx_ack_o,
  output logic              tx_busy_o,
  output logic              tx_o
);

  localparam bit          HasPar = (PARITY != ParNone);
  localparam int unsigned BitW   = $clog2(DATA_W);

  if (!(PARITY == ParOdd || PARITY == ParEven || PARITY == ParNone)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be ODD, EVEN or NONE");
  end
  if (!(STOP_BIT == 1 || STOP_BIT == 2)) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BIT must be 1 or 2");
  end

  function automatic logic calc_par(input logic [DATA_W-1:0] w);
    return (PARITY == ParOdd) ? ~^w : ^w;
  endfunction

  uart_tx_st_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              load;
  logic              brk_req;
  logic              baud_clr;
  logic              bit_end;

`ifdef UART_TX_BREAK_EN
  logic brk_rec_q, brk_rec_d;  // break released, timing the trailing stop bit
  assign brk_req = tx_break_i;
`else
  assign brk_req = 1'b0;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (baud_clr),
    .bit_end_o(bit_end)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ack_d     = 1'b0;
    par_d     = par_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    baud_clr  = (state_q == StIdle);
`ifdef UART_TX_BREAK_EN
    brk_rec_d = brk_rec_q;
    if (state_q == StBreak && !brk_rec_q) begin
      baud_clr = 1'b1;
    end
`endif
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (brk_req) begin
          tx_d    = 1'b0;
          state_d = StBreak;
        end else if (tx_rdy_i) begin
          load = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == BitW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (HasPar) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == BitW'(STOP_BIT - 1)) begin
            // Back-to-back frame when the producer already has the next word.
            if (tx_rdy_i) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        if (!brk_rec_q) begin
          if (!tx_break_i) begin
            tx_d      = 1'b1;
            brk_rec_d = 1'b1;
          end
        end else if (bit_end) begin
          brk_rec_d = 1'b0;
          state_d   = StIdle;
        end
      end
`endif
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
    if (load) begin
      shift_d = tx_data_i;
      par_d   = calc_par(tx_data_i);
      ack_d   = 1'b1;
      tx_d    = 1'b0;
      state_d = StStart;
    end
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset returns the line to idle high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      par_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      par_q     <= par_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef UART_TX_BREAK_EN
  // Break-recovery flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      brk_rec_q <= 1'b0;
    end else begin
      brk_rec_q <= brk_rec_d;
    end
  end
`endif

  assign tx_o      = tx_q;
  assign tx_ack_o  = ack_q;
  assign tx_busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations side by side, CLKS_PER_BIT=4.
// Break test runs when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rdy;
  logic [3:0] tx_w;
  logic [3:0] ack_w;
  logic [3:0] busy_w;
  logic [7:0] dat [4];
  logic       brk;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Expected line bits, LSB = first bit on the line (start bit).
  logic [15:0] exp_s [3] = '{16'h0402, 16'h0404, 16'h0606};

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .PARITY("ODD"), .STOP_BIT(1), .CLKS_PER_BIT(4)) u_odd (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tx_rdy_i (rdy[0]),
    .tx_data_i(dat[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break_i(brk),
`endif
    .tx_ack_o (ack_w[0]),
    .tx_busy_o(busy_w[0]),
    .tx_o     (tx_w[0])
  );

  uart_tx_frame #(.DATA_W(8), .PARITY("EVEN"), .STOP_BIT(1), .CLKS_PER_BIT(4)) u_even (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tx_rdy_i (rdy[1]),
    .tx_data_i(dat[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break_i(1'b0),
`endif
    .tx_ack_o (ack_w[1]),
    .tx_busy_o(busy_w[1]),
    .tx_o     (tx_w[1])
  );

  uart_tx_frame #(.DATA_W(8), .PARITY("NONE"), .STOP_BIT(1), .CLKS_PER_BIT(4)) u_none (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tx_rdy_i (rdy[2]),
    .tx_data_i(dat[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break_i(1'b0),
`endif
    .tx_ack_o (ack_w[2]),
    .tx_busy_o(busy_w[2]),
    .tx_o     (tx_w[2])
  );

  uart_tx_frame #(.DATA_W(7), .PARITY("ODD"), .STOP_BIT(2), .CLKS_PER_BIT(4)) u_s2 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tx_rdy_i (rdy[3]),
    .tx_data_i(dat[3][6:0]),
`ifdef UART_TX_BREAK_EN
    .tx_break_i(1'b0),
`endif
    .tx_ack_o (ack_w[3]),
    .tx_busy_o(busy_w[3]),
    .tx_o     (tx_w[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Send one word on DUT d and check every clock of the frame against exp_bits.
  task automatic send_frame(input int d, input logic [7:0] word, input int nbits,
                            input logic [15:0] exp_bits, input string tag);
    int acks = 0;
    rdy[d] = 1'b1;
    dat[d] = word;
    for (int i = 0; i < nbits * 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check({tag, " ack"}, 32'(ack_w[d]), 32'd1);
        check({tag, " busy"}, 32'(busy_w[d]), 32'd1);
        rdy[d] = 1'b0;
        dat[d] = ~word;
      end else begin
        acks += int'(ack_w[d]);
      end
      check($sformatf("%s tx clk%0d", tag, i), 32'(tx_w[d]), 32'(exp_bits[i / 4]));
    end
    @(negedge clk);
    check({tag, " busy end"}, 32'(busy_w[d]), 32'd0);
    check({tag, " tx end"}, 32'(tx_w[d]), 32'd1);
    check({tag, " extra acks"}, 32'(acks), 32'd0);
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    rdy   = '0;
    brk   = 1'b0;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx_w), 32'hF);
    check("reset busy", 32'(busy_w), 32'h0);
    check("reset ack", 32'(ack_w), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames on each parameterisation.
    send_frame(0, 8'hA5, 11, 16'h074A, "odd_a5");
    send_frame(1, 8'hA5, 11, 16'h054A, "even_a5");
    send_frame(2, 8'hA5, 10, 16'h034A, "none_a5");
    send_frame(3, 8'h7F, 11, 16'h06FE, "stop2_7f");

    // Three back-to-back frames with tx_rdy held high.
    acks   = 0;
    rdy[0] = 1'b1;
    dat[0] = 8'h01;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 44; i++) begin
        @(negedge clk);
        if (ack_w[0]) begin
          acks++;
          dat[0] = 8'(acks + 1);
          if (acks == 3) rdy[0] = 1'b0;
        end
        check($sformatf("stream f%0d tx clk%0d", f, i), 32'(tx_w[0]), 32'(exp_s[f][i / 4]));
      end
    end
    @(negedge clk);
    check("stream busy end", 32'(busy_w[0]), 32'd0);
    check("stream acks", 32'(acks), 32'd3);

    // Asynchronous reset during data bit 3.
    rdy[0] = 1'b1;
    dat[0] = 8'hA5;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) rdy[0] = 1'b0;
    end
    check("pre-rst tx bit3", 32'(tx_w[0]), 32'd0);
    check("pre-rst busy", 32'(busy_w[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid-rst tx", 32'(tx_w[0]), 32'd1);
    check("mid-rst busy", 32'(busy_w[0]), 32'd0);
    check("mid-rst ack", 32'(ack_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(0, 8'h3C, 11, 16'h0678, "post_rst_3c");

`ifdef UART_TX_BREAK_EN
    // Break for 50 clocks with a word pending; break wins over tx_rdy.
    acks   = 0;
    brk    = 1'b1;
    rdy[0] = 1'b1;
    dat[0] = 8'h55;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acks += int'(ack_w[0]);
      check($sformatf("break low clk%0d", i), 32'(tx_w[0]), 32'd0);
      if (i == 49) brk = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acks += int'(ack_w[0]);
      check($sformatf("break stop clk%0d", i), 32'(tx_w[0]), 32'd1);
      check($sformatf("break stop busy%0d", i), 32'(busy_w[0]), 32'd1);
    end
    @(negedge clk);
    check("break idle busy", 32'(busy_w[0]), 32'd0);
    check("break idle tx", 32'(tx_w[0]), 32'd1);
    check("break no ack", 32'(acks + int'(ack_w[0])), 32'd0);
    @(negedge clk);
    check("after break ack", 32'(ack_w[0]), 32'd1);
    check("after break start", 32'(tx_w[0]), 32'd0);
    rdy[0] = 1'b0;
    repeat (44) @(negedge clk);
    check("after break busy end", 32'(busy_w[0]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
